// File: rtl/riscv_sim_ctrl.sv
// Simulation-control peripheral: DONE/CYCLE_LO/CYCLE_HI/STATUS window, 64-bit cycle counter, trap latch.
// Define RISCV_SIM_CTRL_WDOG_EN to enable the watchdog and expose trap_cycle in STATUS[31:4].
module riscv_sim_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0010,
    parameter int unsigned RESP_LAT       = 32'd1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        trap,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        hit,
    output logic        done,
    output logic [31:0] done_code,
    output logic        timeout,
    output logic        trap_seen
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_ACKD = 2'd3
    } state_e;

    localparam logic [3:0] LAT_INIT    = 4'(RESP_LAT - 32'd1);
    localparam logic       DIRECT_RESP = (RESP_LAT == 32'd1);

    state_e      state_q;
    logic [3:0]  lat_q;
    logic [1:0]  off_q;
    logic        instr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [63:0] cycle_q;
    logic [31:0] acc_lo_q;
    logic [31:0] hi_snap_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic [31:0] code_q;
    logic        trap_seen_q;
    logic        timeout_s;
    logic [27:0] trap_tag_s;
    logic        unused_s;

`ifdef RISCV_SIM_CTRL_WDOG_EN
    logic        timeout_q;
    logic [27:0] trap_cycle_q;
    assign timeout_s  = timeout_q;
    assign trap_tag_s = trap_cycle_q;
    assign unused_s   = ^mem_addr[1:0];
`else
    assign timeout_s  = 1'b0;
    assign trap_tag_s = 28'd0;
    assign unused_s   = ^{mem_addr[1:0], TIMEOUT_CYCLES};
`endif

    logic [1:0]  off_s;
    logic        instr_s;
    logic [31:0] wdata_s;
    logic [3:0]  wstrb_s;
    logic [31:0] lo_s;
    logic        is_read_s;
    logic [31:0] code_d;
    logic [31:0] status_s;
    logic [31:0] rd_s;
    logic        do_resp_s;
    logic        done_wr_s;
    logic        done_set_s;

    assign hit       = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign done      = done_q;
    assign done_code = code_q;
    assign timeout   = timeout_s;
    assign trap_seen = trap_seen_q;

    // Request fields come straight from the bus on a single-cycle (IDLE) response, else from the latch.
    always_comb begin
        off_s      = off_q;
        instr_s    = instr_q;
        wdata_s    = wdata_q;
        wstrb_s    = wstrb_q;
        lo_s       = acc_lo_q;
        if (state_q == S_IDLE) begin
            off_s   = mem_addr[3:2];
            instr_s = mem_instr;
            wdata_s = mem_wdata;
            wstrb_s = mem_wstrb;
            lo_s    = cycle_q[31:0];
        end else begin
            off_s   = off_q;
            instr_s = instr_q;
            wdata_s = wdata_q;
            wstrb_s = wstrb_q;
            lo_s    = acc_lo_q;
        end
        is_read_s = instr_s || (wstrb_s == 4'h0);
        code_d    = code_q;
        for (int b = 0; b < 4; b++) begin
            code_d[8*b +: 8] = wstrb_s[b] ? wdata_s[8*b +: 8] : code_q[8*b +: 8];
        end
        status_s = {trap_tag_s, trap_seen_q, timeout_s, done_q, 1'b1};
        if (instr_s) begin
            rd_s = 32'h0;
        end else begin
            case (off_s)
                2'd0:    rd_s = code_q;
                2'd1:    rd_s = lo_s;
                2'd2:    rd_s = hi_snap_q;
                2'd3:    rd_s = status_s;
                default: rd_s = 32'h0;
            endcase
        end
        do_resp_s  = ((state_q == S_IDLE) && hit && DIRECT_RESP) ||
                     ((state_q == S_WAIT) && (lat_q == 4'd1));
        done_wr_s  = do_resp_s && !is_read_s && (off_s == 2'd0);
        done_set_s = done_wr_s && (code_d != 32'h0);
    end

    // Bus FSM, response registers, counter, DONE/trap/watchdog state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lat_q       <= 4'd0;
            off_q       <= 2'd0;
            instr_q     <= 1'b0;
            wdata_q     <= 32'h0;
            wstrb_q     <= 4'h0;
            cycle_q     <= 64'd0;
            acc_lo_q    <= 32'h0;
            hi_snap_q   <= 32'h0;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0;
            done_q      <= 1'b0;
            code_q      <= 32'h0;
            trap_seen_q <= 1'b0;
`ifdef RISCV_SIM_CTRL_WDOG_EN
            timeout_q    <= 1'b0;
            trap_cycle_q <= 28'd0;
`endif
        end else begin
            ready_q <= do_resp_s;
            rdata_q <= (do_resp_s && is_read_s) ? rd_s : 32'h0;

            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        off_q    <= mem_addr[3:2];
                        instr_q  <= mem_instr;
                        wdata_q  <= mem_wdata;
                        wstrb_q  <= mem_wstrb;
                        acc_lo_q <= cycle_q[31:0];
                        lat_q    <= LAT_INIT;
                        state_q  <= DIRECT_RESP ? S_RESP : S_WAIT;
                        // HI is captured with LO so a LO-then-HI read pair is coherent.
                        if ((mem_addr[3:2] == 2'd1) && !mem_instr && (mem_wstrb == 4'h0)) begin
                            hi_snap_q <= cycle_q[63:32];
                        end
                    end
                end
                S_WAIT: begin
                    lat_q <= lat_q - 4'd1;
                    if (lat_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_ACKD;
                end
                S_ACKD: begin
                    if (!mem_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (!done_q && !timeout_s) begin
                cycle_q <= cycle_q + 64'd1;
            end
            if (done_wr_s) begin
                code_q <= code_d;
            end
            if (done_set_s) begin
                done_q <= 1'b1;
            end
            if (trap && !trap_seen_q) begin
                trap_seen_q <= 1'b1;
`ifdef RISCV_SIM_CTRL_WDOG_EN
                trap_cycle_q <= cycle_q[27:0];
`endif
            end
`ifdef RISCV_SIM_CTRL_WDOG_EN
            // A DONE write completing on the expiry edge takes precedence over the watchdog.
            if (!done_q && !timeout_q && !done_set_s && (cycle_q == 64'(TIMEOUT_CYCLES))) begin
                timeout_q <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_riscv_sim_ctrl.sv
// Scoreboard bench for riscv_sim_ctrl: randomized bus traffic against a behavioural model.
module tb_riscv_sim_ctrl;
    localparam int          LAT  = 3;
    localparam int          TMO  = 200;
    localparam logic [31:0] BASE = 32'h0000_0010;
`ifdef RISCV_SIM_CTRL_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        trap = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        hit;
    logic        done;
    logic [31:0] done_code;
    logic        timeout;
    logic        trap_seen;

    riscv_sim_ctrl #(
        .BASE_ADDR      (BASE),
        .RESP_LAT       (LAT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .trap      (trap),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .hit       (hit),
        .done      (done),
        .done_code (done_code),
        .timeout   (timeout),
        .trap_seen (trap_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        bit          rd;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    // Reference model state
    logic [63:0] m_count = 64'd0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_code = 32'h0;
    bit          m_done = 1'b0;
    bit          m_timeout = 1'b0;
    bit          m_trap_seen = 1'b0;
    logic [63:0] m_trap_cycle = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_pins();
        chk("done", 64'(done), 64'(m_done));
        chk("done_code", 64'(done_code), 64'(m_code));
        chk("timeout", 64'(timeout), 64'(m_timeout));
        chk("trap_seen", 64'(trap_seen), 64'(m_trap_seen));
    endtask

    // One clock edge: model applies the rules for this edge, then pins are compared.
    task automatic tick(input bit wr_now, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] merged;
        bit dset, tfire, r, t;
        merged = m_code;
        for (int b = 0; b < 4; b++) begin
            if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
        end
        dset  = wr_now && (merged != 32'h0);
        tfire = WDOG && !m_done && !m_timeout && !dset && (m_count == 64'(TMO));
        r = rst;
        t = trap;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_count = 64'd0; m_hi = 32'h0; m_code = 32'h0; m_done = 1'b0;
            m_timeout = 1'b0; m_trap_seen = 1'b0; m_trap_cycle = 64'd0;
        end else begin
            if (t && !m_trap_seen) begin
                m_trap_seen  = 1'b1;
                m_trap_cycle = m_count;
            end
            if (!m_done && !m_timeout) m_count = m_count + 64'd1;
            if (wr_now) m_code = merged;
            if (dset) m_done = 1'b1;
            if (tfire) m_timeout = 1'b1;
        end
        @(negedge clk);
        check_pins();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_valid = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input bit ins, input int extra);
        bit          hit_e, rd;
        logic [1:0]  off;
        logic [31:0] acc, exp_d, status;
        hit_e = (addr[31:4] == BASE[31:4]);
        rd    = ins || (ws == 4'h0);
        off   = addr[3:2];
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws; mem_instr = ins;
        #1;
        chk("hit", 64'(hit), 64'(hit_e));
        if (!hit_e) begin
            for (int i = 0; i < LAT + 2 + extra; i++) tick(1'b0, 32'h0, 4'h0);
        end else begin
            acc = m_count[31:0];
            if (rd && !ins && (off == 2'd1)) m_hi = m_count[63:32];
            for (int i = 1; i < LAT; i++) tick(1'b0, 32'h0, 4'h0);
            status = {WDOG ? m_trap_cycle[27:0] : 28'h0, m_trap_seen, m_timeout, m_done, 1'b1};
            if (ins) exp_d = 32'h0;
            else if (off == 2'd0) exp_d = m_code;
            else if (off == 2'd1) exp_d = acc;
            else if (off == 2'd2) exp_d = m_hi;
            else exp_d = status;
            sb_q.push_back('{cyc: cyc + 1, data: exp_d, rd: rd});
            tick(!rd && (off == 2'd0), wd, ws);
            for (int i = 0; i < extra; i++) tick(1'b0, 32'h0, 4'h0);
        end
        mem_valid = 1'b0; mem_instr = 1'b0; mem_wstrb = 4'h0;
        idle(2);
    endtask

    // Monitor: every acknowledge must match the oldest expectation, in cycle and data.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready cycle=%0d actual=1 expected=0 rdata=%h", cyc, mem_rdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_latency", 64'(cyc), 64'(e.cyc));
                    if (e.rd) chk("rdata", 64'(mem_rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout cycle=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        int          kind, off, lo, pick;
        logic [31:0] a;

        do_reset();
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);

        idle(50);
        access(32'h14, 32'h0, 4'h0, 1'b0, 0);
        access(32'h18, 32'h0, 4'h0, 1'b0, 0);
        access(32'h1C, 32'h0, 4'h0, 1'b0, 0);
        access(32'h10, 32'h0, 4'h0, 1'b0, 0);

        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 3);
            off  = $urandom_range(0, 3);
            lo   = $urandom_range(0, 3);
            case (kind)
                0: access(BASE + 32'(off * 4 + lo), 32'h0, 4'h0, 1'b0, $urandom_range(0, 2));
                1: access(BASE + 32'($urandom_range(1, 3) * 4), $urandom, 4'($urandom_range(1, 15)), 1'b0, 0);
                2: begin
                    pick = $urandom_range(0, 2);
                    a = (pick == 0) ? 32'h20 : ((pick == 1) ? 32'h0C : 32'h1000_0010);
                    access(a, 32'h0, 4'h0, 1'b0, 0);
                end
                default: access(BASE + 32'(off * 4), 32'h0, 4'h0, 1'b1, 0);
            endcase
            idle($urandom_range(0, 3));
        end

        do_reset();
        idle(40);
        access(32'h10, 32'h0000_0001, 4'hF, 1'b0, 0);
        access(32'h14, 32'h0, 4'h0, 1'b0, 0);
        idle(7);
        access(32'h14, 32'h0, 4'h0, 1'b0, 0);

        do_reset();
        access(32'h10, 32'h0000_AB00, 4'b0010, 1'b0, 0);
        access(32'h10, 32'h0, 4'hF, 1'b0, 0);
        access(32'h10, 32'h0, 4'h0, 1'b0, 0);

        do_reset();
        idle(TMO + 5);
        access(32'h1C, 32'h0, 4'h0, 1'b0, 0);

        do_reset();
        while (m_count < 64'(TMO + 1 - LAT)) tick(1'b0, 32'h0, 4'h0);
        access(32'h10, 32'h0000_0001, 4'hF, 1'b0, 0);
        idle(5);
        access(32'h1C, 32'h0, 4'h0, 1'b0, 0);

        do_reset();
        access(32'h1C, 32'h0, 4'h0, 1'b0, 3);
        access(32'h20, 32'h0, 4'h0, 1'b0, 3);

        do_reset();
        while (m_count < 64'd37) tick(1'b0, 32'h0, 4'h0);
        trap = 1'b1;
        tick(1'b0, 32'h0, 4'h0);
        trap = 1'b0;
        idle(10);
        trap = 1'b1;
        tick(1'b0, 32'h0, 4'h0);
        trap = 1'b0;
        access(32'h1C, 32'h0, 4'h0, 1'b0, 0);
        mem_valid = 1'b1; mem_addr = 32'h1C; mem_wstrb = 4'h0;
        tick(1'b0, 32'h0, 4'h0);
        rst = 1'b1;
        mem_valid = 1'b0;
        tick(1'b0, 32'h0, 4'h0);
        rst = 1'b0;
        chk("post_rst_ready", 64'(mem_ready), 64'd0);
        idle(8);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_sim_ctrl.md
Name: riscv_sim_ctrl

Overview:
- Memory-mapped simulation-control peripheral on the riscv_top core memory bus (mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb/mem_ready/mem_rdata), downstream of the core.
- Decodes the DONE register at 0x00000010 and provides a 64-bit cycle counter, a trap latch and a watchdog.
- Exposes done/timeout/trap status as registers and as pins, so benches and FPGA builds detect completion without hierarchical probing.

Parameters:
- BASE_ADDR, 32'h00000010, 16-byte-aligned base of the 4-register window.
- RESP_LAT, 1, cycles from accept to mem_ready (legal 1..15).
- TIMEOUT_CYCLES, 100000, cycle_count value that fires the watchdog (1 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  core request valid
- mem_instr  in  1  instruction fetch flag
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; 0 = read
- trap  in  1  core trap indication
- mem_ready  out  1  one-cycle acknowledge for a hit
- mem_rdata  out  32  read data, valid while mem_ready=1
- hit  out  1  combinational: mem_valid && address inside window
- done  out  1  sticky, DONE written nonzero
- done_code  out  32  DONE register contents
- timeout  out  1  sticky watchdog flag
- trap_seen  out  1  sticky trap flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. All state is updated on the posedge of clk.
- Reset values: mem_ready=0, mem_rdata=0, done=0, done_code=0, timeout=0, trap_seen=0, cycle_count=0, trap_cycle=0, FSM=IDLE.
- Register map (offsets from BASE_ADDR; mem_addr[1:0] ignored):
  - +0x0 DONE: R/W.
  - +0x4 CYCLE_LO: RO.
  - +0x8 CYCLE_HI: RO.
  - +0xC STATUS: RO, {28'b0, trap_seen, timeout, done, 1'b1}.
- Address decode: hit = mem_valid && mem_addr[31:4]==BASE_ADDR[31:4]. Misses are never acknowledged.
- FSM:
  - IDLE: on hit, latch address/wdata/wstrb and go to WAIT with lat_cnt=RESP_LAT-1. If RESP_LAT=1, go directly to RESP.
  - WAIT: decrement lat_cnt; go to RESP when it reaches 0.
  - RESP: mem_ready=1 for exactly one cycle. Perform the write or drive mem_rdata in this cycle, then go to ACKD.
  - ACKD: mem_ready=0. Go to IDLE once mem_valid=0, so a held valid is never double-acknowledged.
  - Accept-to-ready latency is exactly RESP_LAT cycles.
- Writes:
  - DONE is byte-merged per mem_wstrb.
  - done is set at the RESP edge if the merged value is nonzero.
  - Writing 0 does not clear done.
  - Writes to RO registers are acknowledged and ignored.
- Reads: a snapshot is taken in RESP. CYCLE_LO/HI return cycle_count at the accept cycle; HI is latched together with LO at the LO accept for a coherent 64-bit read.
- mem_instr: a fetch that hits the window is acknowledged with rdata=0.
- cycle_count: 64-bit. Increments every cycle while !rst && !done && !timeout, and freezes once either flag is set. Wraps modulo 2^64.
- Watchdog: timeout is set on the edge where cycle_count==TIMEOUT_CYCLES. If a DONE write completes on that same edge, done wins and timeout stays 0.
- Trap: the first cycle with trap=1 sets trap_seen and captures cycle_count into trap_cycle (internal, visible via the optional feature). Later traps are ignored.
- Reset mid-transaction: FSM returns to IDLE and mem_ready is 0 from the next edge; the in-flight access is dropped.

Optional Feature:
- Macro: RISCV_SIM_CTRL_WDOG_EN.
- Defined: watchdog active as above. An extra register at +0xC returns {trap_cycle[27:0], trap_seen, timeout, done, 1'b1}.
- Undefined: no watchdog logic; timeout is tied to 0; STATUS upper 28 bits read 0.

Test Plan:
- Reset 2 cycles, idle 50 cycles, then read 0x14 -> mem_ready exactly RESP_LAT cycles after accept; rdata = count at accept (~50); 0x18 reads 0.
- Write 0x00000001 wstrb=4'hF to 0x10 -> done=1, done_code=1; cycle_count frozen; subsequent 0x14 reads return the same value.
- Write 0x0000AB00 with wstrb=4'b0010 after reset -> done_code=0x0000AB00, done=1. Then write 0, wstrb=F -> done stays 1, done_code=0.
- TIMEOUT_CYCLES=200, no DONE write -> timeout=1 exactly when count reaches 200; STATUS read = 0x5. Separately, a DONE write landing on that edge -> done=1, timeout=0.
- Hold mem_valid high for 5 cycles on a 0x1C read -> exactly one mem_ready pulse. Access to 0x20 -> hit=0, never ready.
- Pulse trap at count 37, then assert rst during WAIT -> trap_seen=1 before reset, all outputs 0 after reset, no mem_ready emitted.
